fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the multi-cycle RV32I core.
- Owns the fetch PC and drives the synchronous instruction memory read port.
- Tracks in-flight reads over a configurable memory latency and buffers returned words with their PCs in a DEPTH-entry FIFO.
- Presents instructions to the control/decode side with a valid/ready handshake and supports PC redirect with flush (branches, jumps).

Parameters:
- RESET_VECTOR, 32'h1000, first fetch address after reset.
- DEPTH, 4, FIFO entries, power of two, ≥ 2.
- MEM_LATENCY, 1, cycles from imem_address presented to imem_data_out valid, ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_address  out  32  instruction memory read address.
- imem_data_out  in  32  instruction word, valid MEM_LATENCY cycles after its address.
- redirect_valid  in  1  load new fetch PC and flush.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, treated as 0.
- instr_valid  out  1  FIFO head valid.
- instr  out  32  FIFO head instruction word.
- instr_pc  out  32  PC of the FIFO head.
- instr_ready  in  1  consumer accepts head (the ir_write equivalent).
- perf_fetched  out  32  issued-request count (FETCH_PERF_EN).
- perf_stalls  out  32  credit-stall cycles (FETCH_PERF_EN).
- perf_redirects  out  32  redirect count (FETCH_PERF_EN).

Behaviour:
- Reset:
  - fetch_pc = RESET_VECTOR, so imem_address = RESET_VECTOR.
  - FIFO empty; instr_valid = 0; instr and instr_pc = 0.
  - Delay line cleared; perf counters = 0.
  - Reset asserted mid-operation discards all in-flight data.
- imem_address = fetch_pc, combinationally, every cycle.
- Issue rule: issue = !redirect_valid && (occupancy + inflight < DEPTH).
  - Pops in the same cycle are not credited; full throughput needs DEPTH ≥ MEM_LATENCY+2.
- On issue: fetch_pc += 4 (wraps mod 2^32). A tag {valid=1, pc=fetch_pc} enters a MEM_LATENCY-stage shift register.
- When a tag exits with valid=1, {pc, imem_data_out} is pushed into the FIFO at that edge.
- Latency: for an address issued in cycle t, instr_valid rises in cycle t+MEM_LATENCY+1 (FIFO was empty). With MEM_LATENCY=1, the first instruction is valid 2 cycles after reset deasserts.
- Pop: instr_valid && instr_ready at posedge advances the head. The outputs hold stable while instr_valid && !instr_ready.
- Push and pop in the same cycle: occupancy unchanged; a full FIFO may pop and push together.
- Overflow is impossible by the credit rule. The bench checks this with an assertion: a push never occurs while full without a pop.
- Redirect (redirect_valid=1 at posedge):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO emptied; all delay-line valid bits cleared; no issue that cycle.
  - instr_valid = 0 the next cycle.
  - A pop in the same cycle counts as consumed (the consumer took the word); the flush still applies.
  - A redirect during reset is ignored.
- Back-to-back redirects: the last one wins. Fetch resumes the cycle after redirect_valid drops.
- Counters inflight and occupancy are sized $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on each issue.
  - perf_stalls increments each cycle with !issue && !redirect_valid && !reset.
  - perf_redirects increments on each redirect.
  - All three are 32-bit wrapping counters, cleared by reset.
- Undefined: the perf ports are still present but tied to 0 and no counter flops are built, so the port list is identical in both builds.

Decomposition:
- Package fetch_pkg:
  - INSTR_BYTES = 4.
  - NOP_INSTR = 32'h00000013.
  - typedef fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}.
  - typedef fetch_tag_t {logic valid; logic [31:0] pc;}.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, flush, din, dout, count, full, empty; flush is synchronous.
  - Holds fetch_entry_t.
- fetch_unit keeps the PC, the delay line and the credit logic.

Test Plan:
- Reset, MEM_LATENCY=1, DEPTH=4, instr_ready=1, imem model returning address^32'hA5A5_0000 → imem_address 0x1000 in cycle 0; instr_valid in cycle 2 with instr_pc 0x1000; one instruction per cycle after that with PC 0x1004, 0x1008, …
- instr_ready=0 for 10 cycles → exactly 4 entries buffered, imem issue stalls, perf_stalls increments (PERF build), head stays at 0x1000. Release ready → 4 consecutive pops, then streaming resumes gap-free.
- Redirect to 0x2002 while 3 entries are buffered and 1 is in flight → next cycle instr_valid=0; the in-flight word is dropped; first new instr_pc is 0x2000 at MEM_LATENCY+1 cycles after redirect.
- MEM_LATENCY=3, DEPTH=8 → sustained 1 instr/cycle and PC ordering preserved. DEPTH=4 with MEM_LATENCY=3 → credit-limited issue, never overflows.
- fetch_pc = 0xFFFF_FFFC → next issued address 0x0000_0000.
- Reset asserted mid-stream with a full FIFO → next cycle instr_valid=0, imem_address=RESET_VECTOR, perf counters 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Marker for an outstanding memory read, carried through the latency line.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } fetch_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous flush. The head word reads as zero when the
// FIFO is empty. A push into a full FIFO is accepted only together with a pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to a synchronous
// instruction memory, tracks them through a MEM_LATENCY-deep tag line and
// buffers returned words in a DEPTH-entry FIFO. Issue is credit-limited so the
// FIFO can never overflow. Optional perf counters are built when FETCH_PERF_EN
// is defined; otherwise the perf ports read as zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
    parameter int          DEPTH        = 4,
    parameter int          MEM_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_redirects
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]                        fetch_pc;
    fetch_tag_t [MEM_LATENCY-1:0]       tags;
    fetch_tag_t                         tag_out;
    logic [CW-1:0]                      occupancy;
    logic [CW-1:0]                      inflight;
    logic [CW:0]                        credit_used;
    logic                               issue;
    logic                               fifo_push;
    logic                               fifo_pop;
    logic                               fifo_full;
    logic                               fifo_empty;
    fetch_entry_t                       fifo_din;
    fetch_entry_t                       fifo_dout;

    assign imem_address = fetch_pc;
    assign tag_out      = tags[MEM_LATENCY-1];

    // Count outstanding reads still travelling through the latency line.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CW'(tags[i].valid);
        end
    end

    // Buffered plus outstanding words must stay below DEPTH; same-cycle pops
    // are deliberately not credited to keep this path short. The full term is
    // implied by the credit check and only acts as a cheap guard.
    assign credit_used = {1'b0, occupancy} + {1'b0, inflight};
    assign issue       = !redirect_valid && !fifo_full &&
                         (credit_used < (CW+1)'(DEPTH));

    // A word returning in a redirect cycle belongs to the old path: drop it.
    assign fifo_push = tag_out.valid && !redirect_valid;
    assign fifo_pop  = instr_valid && instr_ready;
    assign fifo_din  = {tag_out.pc, imem_data_out};

    // Fetch PC and read-tag line; redirect reloads the PC and kills all tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_VECTOR;
            tags     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            tags     <= '0;
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            tags[0] <= '{valid: issue, pc: fetch_pc};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (occupancy),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_dout.instr;
    assign instr_pc    = fifo_dout.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stalls_q;
    logic [31:0] redirects_q;

    // Wrapping event counters: issued reads, credit stalls, redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q   <= '0;
            stalls_q    <= '0;
            redirects_q <= '0;
        end else begin
            if (issue)                    fetched_q   <= fetched_q + 32'd1;
            if (!issue && !redirect_valid) stalls_q   <= stalls_q + 32'd1;
            if (redirect_valid)           redirects_q <= redirects_q + 32'd1;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_stalls    = stalls_q;
    assign perf_redirects = redirects_q;
`else
    assign perf_fetched   = '0;
    assign perf_stalls    = '0;
    assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances (ML1/D4, ML3/D8, ML3/D4)
// sharing one clock, each with a latency-matched instruction memory model
// returning address ^ 32'hA5A5_0000.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] head;

    // ---------------- DUT A: MEM_LATENCY=1, DEPTH=4 ----------------
    logic        reset_a, redirect_valid_a, instr_ready_a, instr_valid_a;
    logic [31:0] redirect_pc_a, imem_address_a, imem_data_a, instr_a, instr_pc_a;
    logic [31:0] pf_a, ps_a, pr_a;

    fetch_unit #(.RESET_VECTOR(32'h1000), .DEPTH(4), .MEM_LATENCY(1)) u_a (
        .clk(clk), .reset(reset_a), .imem_address(imem_address_a), .imem_data_out(imem_data_a),
        .redirect_valid(redirect_valid_a), .redirect_pc(redirect_pc_a),
        .instr_valid(instr_valid_a), .instr(instr_a), .instr_pc(instr_pc_a), .instr_ready(instr_ready_a),
        .perf_fetched(pf_a), .perf_stalls(ps_a), .perf_redirects(pr_a));

    always @(posedge clk) imem_data_a <= imem_address_a ^ KEY;

    // ---------------- DUT B: MEM_LATENCY=3, DEPTH=8 ----------------
    logic        reset_b, instr_ready_b, instr_valid_b;
    logic [31:0] imem_address_b, imem_data_b, instr_b, instr_pc_b, pf_b, ps_b, pr_b;
    logic [31:0] pipe_b [3];

    fetch_unit #(.RESET_VECTOR(32'h1000), .DEPTH(8), .MEM_LATENCY(3)) u_b (
        .clk(clk), .reset(reset_b), .imem_address(imem_address_b), .imem_data_out(imem_data_b),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(instr_valid_b), .instr(instr_b), .instr_pc(instr_pc_b), .instr_ready(instr_ready_b),
        .perf_fetched(pf_b), .perf_stalls(ps_b), .perf_redirects(pr_b));

    always @(posedge clk) begin
        pipe_b[0] <= imem_address_b ^ KEY;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign imem_data_b = pipe_b[2];

    // ---------------- DUT C: MEM_LATENCY=3, DEPTH=4 ----------------
    logic        reset_c, instr_ready_c, instr_valid_c;
    logic [31:0] imem_address_c, imem_data_c, instr_c, instr_pc_c, pf_c, ps_c, pr_c;
    logic [31:0] pipe_c [3];

    fetch_unit #(.RESET_VECTOR(32'h1000), .DEPTH(4), .MEM_LATENCY(3)) u_c (
        .clk(clk), .reset(reset_c), .imem_address(imem_address_c), .imem_data_out(imem_data_c),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(instr_valid_c), .instr(instr_c), .instr_pc(instr_pc_c), .instr_ready(instr_ready_c),
        .perf_fetched(pf_c), .perf_stalls(ps_c), .perf_redirects(pr_c));

    always @(posedge clk) begin
        pipe_c[0] <= imem_address_c ^ KEY;
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
    end
    assign imem_data_c = pipe_c[2];

    // No push may land on a full FIFO unless a pop frees a slot that cycle.
    always @(negedge clk) begin
        if (!reset_a) assert (!(u_a.fifo_push && u_a.fifo_full && !u_a.fifo_pop)) else $error("FAIL overflow_a");
        if (!reset_b) assert (!(u_b.fifo_push && u_b.fifo_full && !u_b.fifo_pop)) else $error("FAIL overflow_b");
        if (!reset_c) assert (!(u_c.fifo_push && u_c.fifo_full && !u_c.fifo_pop)) else $error("FAIL overflow_c");
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset values; a redirect during reset must be ignored.
    task automatic test_reset();
        reset_a = 1'b1; redirect_valid_a = 1'b1; redirect_pc_a = 32'h5000; instr_ready_a = 1'b1;
        step(); step();
        total++;
        if (imem_address_a !== 32'h1000) begin bad++; $display("FAIL reset_redirect_ignored: got %h want %h", imem_address_a, 32'h1000); end
        redirect_valid_a = 1'b0;
        step();
        total++;
        if ({instr_valid_a, instr_a, instr_pc_a} !== {1'b0, 64'h0}) begin
            bad++; $display("FAIL reset_outputs: got v=%0b i=%h pc=%h want 0/0/0", instr_valid_a, instr_a, instr_pc_a);
        end
        total++;
        if ({pf_a, ps_a, pr_a} !== 96'h0) begin bad++; $display("FAIL reset_perf: got %h %h %h want 0", pf_a, ps_a, pr_a); end
        reset_a = 1'b0;   // cycle 0 starts here
    endtask

    // First fetch latency: address in cycle 0, head valid in cycle 2.
    task automatic test_first_fetch();
        total++;
        if (imem_address_a !== 32'h1000) begin bad++; $display("FAIL first_addr: got %h want %h", imem_address_a, 32'h1000); end
        step();
        total++;
        if (instr_valid_a !== 1'b0 || imem_address_a !== 32'h1004) begin
            bad++; $display("FAIL cycle1: got v=%0b addr=%h want v=0 addr=1004", instr_valid_a, imem_address_a);
        end
        step();
        total++;
        if (instr_valid_a !== 1'b1 || instr_pc_a !== 32'h1000 || instr_a !== (32'h1000 ^ KEY)) begin
            bad++; $display("FAIL first_instr: got v=%0b pc=%h i=%h want pc=1000 i=%h", instr_valid_a, instr_pc_a, instr_a, 32'h1000 ^ KEY);
        end
    endtask

    // Steady streaming, one instruction per cycle.
    task automatic test_stream();
        for (int i = 1; i <= 5; i++) begin
            step();
            total++;
            if (instr_valid_a !== 1'b1 || instr_pc_a !== 32'h1000 + 32'(4*i) || instr_a !== ((32'h1000 + 32'(4*i)) ^ KEY)) begin
                bad++; $display("FAIL stream[%0d]: got v=%0b pc=%h want pc=%h", i, instr_valid_a, instr_pc_a, 32'h1000 + 32'(4*i));
            end
        end
        head = 32'h1014;
    endtask

    // Back-pressure: FIFO fills, issue stalls, head holds; release drains gap-free.
    task automatic test_stall();
        logic [31:0] pf0, ps0, exp_pf, exp_ps;
        pf0 = pf_a; ps0 = ps_a;
`ifdef FETCH_PERF_EN
        exp_pf = 32'd2; exp_ps = 32'd8;
`else
        exp_pf = 32'd0; exp_ps = 32'd0;
`endif
        instr_ready_a = 1'b0;
        repeat (10) step();
        total++;
        if (instr_valid_a !== 1'b1 || instr_pc_a !== head) begin
            bad++; $display("FAIL stall_head: got v=%0b pc=%h want pc=%h", instr_valid_a, instr_pc_a, head);
        end
        total++;
        if (imem_address_a !== head + 32'd16) begin bad++; $display("FAIL stall_addr: got %h want %h", imem_address_a, head + 32'd16); end
        total++;
        if (ps_a - ps0 !== exp_ps || pf_a - pf0 !== exp_pf) begin
            bad++; $display("FAIL stall_perf: got stalls+%0d fetched+%0d want +%0d +%0d", ps_a - ps0, pf_a - pf0, exp_ps, exp_pf);
        end
        instr_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (instr_valid_a !== 1'b1 || instr_pc_a !== head + 32'(4*i)) begin
                bad++; $display("FAIL drain[%0d]: got v=%0b pc=%h want pc=%h", i, instr_valid_a, instr_pc_a, head + 32'(4*i));
            end
            step();
        end
        head = head + 32'd32;
    endtask

    // Redirect with 3 buffered and 1 in flight; misaligned target is aligned.
    task automatic test_redirect();
        instr_ready_a = 1'b0;
        step();
        total++;
        if (instr_pc_a !== head) begin bad++; $display("FAIL pre_redirect_head: got %h want %h", instr_pc_a, head); end
        redirect_valid_a = 1'b1; redirect_pc_a = 32'h2002;
        step();
        total++;
        if (instr_valid_a !== 1'b0 || imem_address_a !== 32'h2000) begin
            bad++; $display("FAIL redirect_flush: got v=%0b addr=%h want v=0 addr=2000", instr_valid_a, imem_address_a);
        end
        redirect_valid_a = 1'b0; instr_ready_a = 1'b1;
        step();
        total++;
        if (instr_valid_a !== 1'b0 || imem_address_a !== 32'h2004) begin
            bad++; $display("FAIL redirect_issue: got v=%0b addr=%h want v=0 addr=2004", instr_valid_a, imem_address_a);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (instr_valid_a !== 1'b1 || instr_pc_a !== 32'h2000 + 32'(4*i) || instr_a !== ((32'h2000 + 32'(4*i)) ^ KEY)) begin
                bad++; $display("FAIL redirect_stream[%0d]: got v=%0b pc=%h want pc=%h", i, instr_valid_a, instr_pc_a, 32'h2000 + 32'(4*i));
            end
        end
    endtask

    // Two redirects in a row (last wins) into the top of the address space.
    task automatic test_back_to_back_wrap();
        logic [31:0] exp_pc;
        redirect_valid_a = 1'b1; redirect_pc_a = 32'h3000;
        step();
        total++;
        if (instr_valid_a !== 1'b0 || imem_address_a !== 32'h3000) begin
            bad++; $display("FAIL b2b_first: got v=%0b addr=%h want v=0 addr=3000", instr_valid_a, imem_address_a);
        end
        redirect_pc_a = 32'hFFFF_FFFF;
        step();
        total++;
        if (instr_valid_a !== 1'b0 || imem_address_a !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL b2b_last: got v=%0b addr=%h want v=0 addr=fffffffc", instr_valid_a, imem_address_a);
        end
        redirect_valid_a = 1'b0;
        step();
        total++;
        if (imem_address_a !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 00000000", imem_address_a); end
        exp_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (instr_valid_a !== 1'b1 || instr_pc_a !== exp_pc || instr_a !== (exp_pc ^ KEY)) begin
                bad++; $display("FAIL wrap_stream[%0d]: got v=%0b pc=%h want pc=%h", i, instr_valid_a, instr_pc_a, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        head = 32'h4;
    endtask

    // Reset with a full FIFO discards everything and clears the counters.
    task automatic test_reset_mid();
        instr_ready_a = 1'b0;
        repeat (6) step();
        total++;
        if (instr_valid_a !== 1'b1 || instr_pc_a !== head) begin
            bad++; $display("FAIL full_head: got v=%0b pc=%h want pc=%h", instr_valid_a, instr_pc_a, head);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (pr_a !== 32'd3) begin bad++; $display("FAIL perf_redirects: got %0d want 3", pr_a); end
`endif
        reset_a = 1'b1;
        step();
        total++;
        if (instr_valid_a !== 1'b0 || imem_address_a !== 32'h1000 || instr_a !== 32'h0 || instr_pc_a !== 32'h0) begin
            bad++; $display("FAIL reset_mid: got v=%0b addr=%h i=%h pc=%h want 0/1000/0/0", instr_valid_a, imem_address_a, instr_a, instr_pc_a);
        end
        total++;
        if ({pf_a, ps_a, pr_a} !== 96'h0) begin bad++; $display("FAIL reset_mid_perf: got %h %h %h want 0", pf_a, ps_a, pr_a); end
        reset_a = 1'b0;
    endtask

    // Latency 3 with enough credit: full rate, ordered PCs.
    task automatic test_lat3_sustained();
        logic [31:0] exp_pc;
        reset_b = 1'b0;
        exp_pc = 32'h1000;
        for (int m = 0; m < 16; m++) begin
            total++;
            if (imem_address_b !== 32'h1000 + 32'(4*m)) begin
                bad++; $display("FAIL lat3_addr[%0d]: got %h want %h", m, imem_address_b, 32'h1000 + 32'(4*m));
            end
            total++;
            if (m < 4) begin
                if (instr_valid_b !== 1'b0) begin bad++; $display("FAIL lat3_early[%0d]: got v=%0b want 0", m, instr_valid_b); end
            end else begin
                if (instr_valid_b !== 1'b1 || instr_pc_b !== exp_pc || instr_b !== (exp_pc ^ KEY)) begin
                    bad++; $display("FAIL lat3_stream[%0d]: got v=%0b pc=%h want pc=%h", m, instr_valid_b, instr_pc_b, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
            step();
        end
    endtask

    // Latency 3 with DEPTH 4: one bubble every five cycles, never overflows.
    task automatic test_credit_limited();
        logic [31:0] exp_pc, exp_addr;
        logic        exp_v;
        reset_c = 1'b0;
        exp_pc = 32'h1000; exp_addr = 32'h1000;
        for (int m = 0; m < 18; m++) begin
            exp_v = (m >= 4) && ((m - 4) % 5 != 4);
            total++;
            if (imem_address_c !== exp_addr) begin bad++; $display("FAIL credit_addr[%0d]: got %h want %h", m, imem_address_c, exp_addr); end
            total++;
            if (instr_valid_c !== exp_v || (exp_v && instr_pc_c !== exp_pc)) begin
                bad++; $display("FAIL credit_head[%0d]: got v=%0b pc=%h want v=%0b pc=%h", m, instr_valid_c, instr_pc_c, exp_v, exp_pc);
            end
            if (exp_v) exp_pc = exp_pc + 32'd4;
            if (!(m >= 4 && (m - 4) % 5 == 0)) exp_addr = exp_addr + 32'd4;
            step();
        end
    endtask

    initial begin
        reset_a = 1'b1; redirect_valid_a = 1'b0; redirect_pc_a = 32'h0; instr_ready_a = 1'b1;
        reset_b = 1'b1; instr_ready_b = 1'b1;
        reset_c = 1'b1; instr_ready_c = 1'b1;
        head = 32'h0;
        test_reset();
        test_first_fetch();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back_wrap();
        test_reset_mid();
        test_lat3_sustained();
        test_credit_limited();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
